// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit ID constants, length width and input-buffer FSM state type
package noc_pkg;

    localparam logic [2:0] FLIT_NONE   = 3'b000;
    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int LEN_W = 12;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - register-array flit FIFO with combinational head, full and empty
module flit_fifo #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] din,
    input  logic              pop,
    output logic [FLIT_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - NoC router per-port input stage; option macro INBUF_CREDIT_EN
import noc_pkg::*;

module input_buffer #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
`ifdef INBUF_CREDIT_EN
    output logic              credit_out,
`else
    output logic              in_ready,
`endif
    input  logic              grant,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              err_drop
);

    logic [FLIT_W-1:0] head;
    logic [2:0]        head_id;
    logic              full;
    logic              empty;
    logic              head_is_hdr;
    logic              fwd;
    logic              drop;
    logic              pop;
    logic              push;
    logic              overflow;
    state_t            state;
    logic [LEN_W-1:0]  len_q;

    flit_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_flit),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_id     = head[FLIT_W-1 -: 3];
    assign head_is_hdr = !empty && (head_id == FLIT_HEADER);

    // Outside a packet only a header may lead; anything else is discarded.
    assign drop      = (state == ST_IDLE) && !empty && !head_is_hdr;
    assign out_valid = !empty && ((state == ST_ACTIVE) || head_is_hdr);
    assign fwd       = out_valid && out_ready && grant;
    assign pop       = fwd || drop;

`ifdef INBUF_CREDIT_EN
    // A full FIFO still takes a flit in the same cycle a slot is freed.
    assign overflow = in_valid && full && !pop;
    assign push     = in_valid && !overflow;
`else
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign overflow = 1'b0;
`endif

    assign req      = head_is_hdr || (state == ST_ACTIVE);
    assign flit_id  = out_valid ? head_id : FLIT_NONE;
    assign length   = head_is_hdr ? head[LEN_W-1:0] : len_q;
    assign out_flit = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            err_drop <= 1'b0;
`ifdef INBUF_CREDIT_EN
            credit_out <= 1'b0;
`endif
        end else begin
            err_drop <= drop || overflow;
`ifdef INBUF_CREDIT_EN
            credit_out <= pop;
`endif
            if (fwd && head_is_hdr) len_q <= head[LEN_W-1:0];
            case (state)
                ST_IDLE:   if (head_is_hdr) state <= ST_ACTIVE;
                ST_ACTIVE: if (fwd && (head_id == FLIT_TAIL)) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// tb/tb_input_buffer.sv - randomized and directed bench for input_buffer against a queue model
module tb_input_buffer;
    import noc_pkg::*;

    localparam int DEPTH  = 4;
    localparam int FLIT_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              grant;
    logic              out_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              req;
    logic [2:0]        flit_id;
    logic [LEN_W-1:0]  length;
    logic              err_drop;
`ifdef INBUF_CREDIT_EN
    logic              credit_out;
`else
    logic              in_ready;
`endif

    always #5 clk = ~clk;

    input_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
`ifdef INBUF_CREDIT_EN
        .credit_out(credit_out),
`else
        .in_ready  (in_ready),
`endif
        .grant     (grant),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .req       (req),
        .flit_id   (flit_id),
        .length    (length),
        .err_drop  (err_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [FLIT_W-1:0] model_q[$];
    bit                m_active;
    logic [LEN_W-1:0]  m_len;
    bit                m_err;
    bit                m_credit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [2:0] id, input logic [11:0] len);
        logic [16:0] mid;
        mid = 17'($urandom);
        return {id, mid, len};
    endfunction

    task automatic check_outputs();
        bit nonempty, hdr, ov;
        logic [FLIT_W-1:0] h;
        logic [2:0] hid;
        nonempty = model_q.size() > 0;
        h   = nonempty ? model_q[0] : '0;
        hid = h[FLIT_W-1 -: 3];
        hdr = nonempty && (hid == FLIT_HEADER);
        ov  = nonempty && (m_active || hdr);
        check("out_valid", out_valid, ov);
        check("req", req, m_active || hdr);
        check("flit_id", flit_id, ov ? hid : FLIT_NONE);
        check("length", length, hdr ? h[11:0] : m_len);
        check("err_drop", err_drop, m_err);
        if (ov) check("out_flit", out_flit, h);
`ifdef INBUF_CREDIT_EN
        check("credit_out", credit_out, m_credit);
`else
        check("in_ready", in_ready, model_q.size() < DEPTH);
`endif
    endtask

    // Applies one clock of the spec's rules to the queue model; returns whether the flit was taken.
    task automatic model_update(input logic v, input logic [FLIT_W-1:0] f,
                                input logic g, input logic r, output bit acc);
        bit nonempty, hdr, ov, fwd, drop, full;
        logic [FLIT_W-1:0] h;
        logic [2:0] hid;
        nonempty = model_q.size() > 0;
        full = model_q.size() == DEPTH;
        h    = nonempty ? model_q[0] : '0;
        hid  = h[FLIT_W-1 -: 3];
        hdr  = nonempty && (hid == FLIT_HEADER);
        ov   = nonempty && (m_active || hdr);
        fwd  = ov && r && g;
        drop = nonempty && !m_active && !hdr;
`ifdef INBUF_CREDIT_EN
        acc      = v && (!full || fwd || drop);
        m_err    = drop || (v && !acc);
        m_credit = fwd || drop;
`else
        acc   = v && !full;
        m_err = drop;
`endif
        if (fwd && hdr) m_len = h[11:0];
        if (!m_active && hdr) m_active = 1'b1;
        else if (m_active && fwd && hid == FLIT_TAIL) m_active = 1'b0;
        if (fwd || drop) void'(model_q.pop_front());
        if (acc) model_q.push_back(f);
    endtask

    task automatic step(input logic v, input logic [FLIT_W-1:0] f,
                        input logic g, input logic r, output bit acc);
        in_valid  = v;
        in_flit   = f;
        grant     = g;
        out_ready = r;
        check_outputs();
        @(posedge clk);
        model_update(v, f, g, r, acc);
        #1;
    endtask

    task automatic idle(input int n, input logic g, input logic r);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, g, r, acc);
    endtask

    task automatic send(input logic [FLIT_W-1:0] f, input logic g, input logic r);
        bit acc;
        int k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            step(1'b1, f, g, r, acc);
            k++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        m_active = 1'b0;
        m_len    = '0;
        m_err    = 1'b0;
        m_credit = 1'b0;
    endtask

    initial begin
        bit acc;
        logic [FLIT_W-1:0] f5;
        int pick;
        logic [2:0] id;
        in_valid  = 1'b0;
        in_flit   = '0;
        grant     = 1'b0;
        out_ready = 1'b0;

        do_reset();
        idle(10, 1'b0, 1'b0);

        // Header length 5, body, tail with grant and ready held.
        send(mk(FLIT_HEADER, 12'd5), 1'b1, 1'b1);
        send(mk(FLIT_BODY, 12'h0a5), 1'b1, 1'b1);
        send(mk(FLIT_TAIL, 12'h35a), 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Back-pressure: fifth flit waits upstream until a pop frees a slot.
        do_reset();
        send(mk(FLIT_HEADER, 12'd4), 1'b1, 1'b0);
        send(mk(FLIT_BODY, 12'd1), 1'b1, 1'b0);
        send(mk(FLIT_BODY, 12'd2), 1'b1, 1'b0);
        send(mk(FLIT_BODY, 12'd3), 1'b1, 1'b0);
        f5 = mk(FLIT_TAIL, 12'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, f5, 1'b1, 1'b0, acc);
`ifndef INBUF_CREDIT_EN
            check("held_upstream", acc, 1'b0);
`endif
        end
        send(f5, 1'b1, 1'b1);
        idle(6, 1'b1, 1'b1);

        // Stray body in IDLE is dropped, then a header is requested normally.
        do_reset();
        send(mk(FLIT_BODY, 12'h111), 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        send(mk(FLIT_HEADER, 12'h222), 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b1);
        send(mk(FLIT_TAIL, 12'h333), 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);

        // Grant withdrawn after two of four flits.
        do_reset();
        send(mk(FLIT_HEADER, 12'd4), 1'b0, 1'b0);
        send(mk(FLIT_BODY, 12'd7), 1'b0, 1'b0);
        send(mk(FLIT_BODY, 12'd8), 1'b0, 1'b0);
        send(mk(FLIT_TAIL, 12'd9), 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1);
        idle(4, 1'b0, 1'b1);
        idle(4, 1'b1, 1'b1);

        // Reset mid-packet discards buffered flits.
        send(mk(FLIT_HEADER, 12'd3), 1'b0, 1'b0);
        send(mk(FLIT_BODY, 12'd3), 1'b0, 1'b0);
        do_reset();
        idle(3, 1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 30)      id = FLIT_HEADER;
            else if (pick < 60) id = FLIT_BODY;
            else if (pick < 85) id = FLIT_TAIL;
            else                id = 3'($urandom);
            step(1'($urandom_range(0, 99) < 60), mk(id, 12'($urandom)),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 70), acc);
        end
        idle(3, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_buffer.md
# input_buffer

Per-port input stage of the 5-port NoC router, instantiated once each for L, N, E, W and S. It buffers incoming flits in a FIFO and tracks packet boundaries from the flit IDs. It raises the port's request to the arbiter, supplies the arbiter's timer with the head flit ID and packet length, and releases flits to the crossbar only while the arbiter grants the port.

## Interface
- DEPTH, 8: FIFO entries, power of two, ≥2
- FLIT_W, 32: flit width; [FLIT_W-1:FLIT_W-3] flit ID, [11:0] of a header flit = packet length
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- in_flit  in  FLIT_W  flit from link
- in_valid  in  1  in_flit valid
- in_ready  out  1  buffer accepts flit (absent under INBUF_CREDIT_EN)
- grant  in  1  this port's bit of the arbiter's one-hot next-state
- out_ready  in  1  crossbar/downstream can take a flit
- out_flit  out  FLIT_W  head-of-FIFO flit
- out_valid  out  1  out_flit is valid and forwardable
- req  out  1  request to arbiter (Lreq/Nreq/…)
- flit_id  out  3  head flit ID to arbiter timer; 3'b000 when nothing valid
- length  out  12  packet length to arbiter timer
- err_drop  out  1  one-cycle pulse: malformed flit discarded

## Operation
- Flit IDs: 3'b001 header, 3'b010 body, 3'b100 tail; any other ID is malformed.
- Push: in_valid && in_ready. in_ready = !full.
- Pop (forward): out_valid && out_ready && grant.
- Packet FSM states:
  - IDLE
    - Empty: no action.
    - Head is a header: go to ACTIVE.
    - Head is anything else: pop it silently, pulse err_drop, stay IDLE.
  - ACTIVE: req=1.
    - Popping a tail: return to IDLE.
    - Popping a header while ACTIVE: allowed; restarts packet tracking; no error.
- req = (state==IDLE && head is header) || state==ACTIVE.
  - req stays high while ACTIVE even if the FIFO is momentarily empty, so the arbiter keeps the grant.
- out_valid = !empty && (state==ACTIVE || head is header). Never asserted for a flit being dropped.
- flit_id = head flit ID when out_valid, else 3'b000.
- length = head[11:0] when head is a header; otherwise the last header length captured on pop, held.
- Grant withdrawn mid-packet (arbiter timeout): flits stay buffered, req stays high, forwarding resumes on the next grant.
- Arithmetic: pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy count log2(DEPTH)+1 bits.

## Timing
- Reset values: in_ready=1, out_valid=0, req=0, flit_id=3'b000, length=0, err_drop=0, FIFO empty, state IDLE.
- Reset mid-packet discards all buffered flits.
- Latency: a pushed flit appears at out_flit the next cycle. Header push in cycle N gives req=1 in cycle N+1.
- Simultaneous push and pop: occupancy unchanged. Allowed when full only under INBUF_CREDIT_EN, since in_ready gates push otherwise.
- FSM, flit_id, req and out_valid are combinational from registered head/state; no combinational path from grant to req.
- err_drop is registered, asserted the cycle after the drop.

## Configuration
- INBUF_CREDIT_EN defined:
  - in_ready is removed; output credit_out (1 bit) pulses once per pop or drop.
  - The upstream sender holds DEPTH credits after reset.
  - A push while full is a protocol violation; the flit is ignored and err_drop pulses.
- INBUF_CREDIT_EN undefined: valid/ready flow control as above; no credit_out port.

## Structure
- noc_pkg holds:
  - FLIT_HEADER, FLIT_BODY, FLIT_TAIL, FLIT_NONE constants
  - LEN_W = 12
  - the FSM state typedef
- Sub-module flit_fifo(DEPTH, FLIT_W): register-array FIFO with push, pop, head, full, empty.
- input_buffer holds the FSM, drop logic and arbiter-facing outputs.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values, req=0, flit_id=000.
- Push header(length=12'd5), body, tail with grant=1 and out_ready=1 -> req high from cycle after header push; flit_id=001 and length=5 on that cycle; three pops; req low the cycle after tail pop.
- DEPTH=4, out_ready=0, push 5 flits -> in_ready low after 4th push. 5th is held upstream until the first pop, then accepted.
- Push body flit with FSM IDLE -> flit popped without out_valid; err_drop pulses once; a following header is then requested normally.
- Grant 1→0 after 2 of 4 flits -> out_valid stays, no pops, req stays 1; grant back to 1 -> remaining 2 flits forwarded in order.
- INBUF_CREDIT_EN build: 8 pops -> 8 credit_out pulses. Push into full FIFO -> flit ignored, err_drop=1.
